axi_llc_way_arb: RTL and testbench
==================================

// Module: axi_llc_way_arb
// PURPOSE
//  Shares one data way (single-port SRAM, 1-cycle read latency, valid/ready in and out) among
//  NumUnits cache units (e.g. evict, refill, write, read). Round-robin grant with optional burst
//  lock, so a unit's line transfer stays contiguous. Caps outstanding reads; routes read responses
//  back to the issuing unit by the cache_unit field. Sits between the unit request muxes and one
//  data way instance.
// PARAMETERS
//  NumUnits        4          number of requesting units; unit index i in [0,NumUnits-1]
//  MaxBurst        4          max consecutive grants held by one unit while it stays valid (>=1)
//  MaxOutstanding  2          max read requests issued but not yet answered (>=1)
//  way_inp_t       logic      way request struct; fields cache_unit, we, line_addr, blk_offset, data, strb
//  way_oup_t       logic      way response struct; fields cache_unit, data
// PORTS
//  clk_i            in   1                    clock, rising edge
//  rst_ni           in   1                    asynchronous reset, active low
//  req_i            in   NumUnits x way_inp_t per-unit request; unit i drives cache_unit == i
//  req_valid_i      in   NumUnits             per-unit request valid
//  req_ready_o      out  NumUnits             per-unit request accepted
//  way_o            out  way_inp_t            request to data way (= req_i[sel])
//  way_valid_o      out  1                    request valid to data way
//  way_ready_i      in   1                    data way ready
//  way_rsp_i        in   way_oup_t            read response from data way
//  way_rsp_valid_i  in   1                    response valid
//  way_rsp_ready_o  out  1                    response consumed
//  rsp_o            out  way_oup_t            response broadcast to all units (= way_rsp_i)
//  rsp_valid_o      out  NumUnits             one-hot response valid, index = way_rsp_i.cache_unit
//  rsp_ready_i      in   NumUnits             per-unit response ready
//  route_err_o      out  1                    1-cycle pulse: response with cache_unit >= NumUnits dropped
// BEHAVIOUR
//  Reset: rr_ptr=0, state IDLE, burst_cnt=0, out_cnt=0, hold=0; with all inputs low every output is 0.
//  Request path combinational (zero latency): way_o=req_i[sel]; way_valid_o=req_valid_i[sel]&eligible;
//   req_ready_o[sel]=way_ready_i&eligible; other req_ready_o bits 0. Handshake = way_valid_o&way_ready_i.
//  eligible = req_i[sel].we | (out_cnt < MaxOutstanding); a read blocked by the cap drives valid low.
//  Selection:
//   - hold=1: sel=held index (set when way_valid_o&!way_ready_i, cleared on handshake); keeps
//     way_o stable. A unit must not drop valid while hold=1.
//   - LOCK: sel=lock_idx while req_valid_i[lock_idx]; if it drops, go IDLE, same-cycle RR pick.
//   - IDLE: first valid eligible unit at or after rr_ptr, wrapping mod NumUnits.
//  State machine on each handshake by unit s:
//   - IDLE->LOCK(lock_idx=s, burst_cnt=1) if MaxBurst>1.
//   - LOCK: burst_cnt+1; at burst_cnt==MaxBurst go IDLE.
//   - On leaving LOCK or on any IDLE grant: rr_ptr=(s+1) mod NumUnits.
//  out_cnt: +1 on read handshake (we=0), -1 on response handshake, unchanged if both same cycle.
//   Never exceeds MaxOutstanding, never underflows; width $clog2(MaxOutstanding+1).
//  Response path combinational: idx=way_rsp_i.cache_unit; rsp_valid_o[idx]=way_rsp_valid_i;
//   way_rsp_ready_o=rsp_ready_i[idx]; rsp_o=way_rsp_i. idx>=NumUnits: way_rsp_ready_o=1,
//   no rsp_valid_o, route_err_o=1 that cycle, out_cnt still decrements.
//  A stalled response (valid&!ready) keeps way stalled upstream; no internal response buffering.
//  Mid-operation reset: async clear to reset state; in-flight accounting lost (way reset alongside).
// TESTING
//  Units 0,2 valid, reads, MaxBurst=1, rsp ready -> grants alternate 0,2,0,2; rr_ptr wraps 3->0.
//  Unit 1 streams 8 writes, unit 3 valid, MaxBurst=4 -> 1,1,1,1,3,1,1,1,1; 3 never starves.
//  MaxOutstanding=2, 3 reads, rsp_ready_i=0 -> 2 issue, 3rd has way_valid_o=0; one rsp -> issues.
//  Read handshake and response handshake same cycle at out_cnt=1 -> out_cnt stays 1.
//  way_ready_i=0 for 3 cycles while higher-RR unit raises valid -> way_o stable, sel unchanged.
//  Response with cache_unit=5 (NumUnits=4) -> way_rsp_ready_o=1, rsp_valid_o=0, route_err_o pulses 1 cycle.

Source files
------------

// File: rtl/axi_llc_way_arb.sv
// rtl/axi_llc_way_arb.sv - round-robin data-way arbiter with burst lock and read cap
// Shares one single-port data way among cache units and routes read responses back by cache_unit.

package axi_llc_way_arb_pkg;
  typedef struct packed {
    logic [3:0]  cache_unit;
    logic        we;
    logic [9:0]  line_addr;
    logic [1:0]  blk_offset;
    logic [31:0] data;
    logic [3:0]  strb;
  } way_inp_t;

  typedef struct packed {
    logic [3:0]  cache_unit;
    logic [31:0] data;
  } way_oup_t;
endpackage

module axi_llc_way_arb #(
  parameter int unsigned NumUnits       = 4,
  parameter int unsigned MaxBurst       = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter type         way_inp_t      = axi_llc_way_arb_pkg::way_inp_t,
  parameter type         way_oup_t      = axi_llc_way_arb_pkg::way_oup_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  way_inp_t            req_i [NumUnits],
  input  logic [NumUnits-1:0] req_valid_i,
  output logic [NumUnits-1:0] req_ready_o,
  output way_inp_t            way_o,
  output logic                way_valid_o,
  input  logic                way_ready_i,
  input  way_oup_t            way_rsp_i,
  input  logic                way_rsp_valid_i,
  output logic                way_rsp_ready_o,
  output way_oup_t            rsp_o,
  output logic [NumUnits-1:0] rsp_valid_o,
  input  logic [NumUnits-1:0] rsp_ready_i,
  output logic                route_err_o
);
  localparam int unsigned IdxW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
  localparam int unsigned BcW  = $clog2(MaxBurst + 1);
  localparam int unsigned OcW  = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {IDLE, LOCK} state_e;

  state_e         state_q, state_d;
  idx_t           rr_ptr_q, rr_ptr_d;
  idx_t           lock_idx_q, lock_idx_d;
  idx_t           hold_idx_q, hold_idx_d;
  logic [BcW-1:0] burst_cnt_q, burst_cnt_d;
  logic [OcW-1:0] out_cnt_q, out_cnt_d;
  logic           hold_q, hold_d;

  logic                can_read;
  logic [NumUnits-1:0] eligible;
  logic                lock_live, rr_found, sel_ok;
  logic                handshake, rd_hs, rsp_hs;
  logic                rsp_in_range;
  logic [BcW-1:0]      burst_inc;
  idx_t                sel, rr_sel, sel_next;
  int unsigned         rsp_idx;

  // Writes never count toward the outstanding-read cap.
  always_comb begin
    can_read = (out_cnt_q < OcW'(MaxOutstanding));
    eligible = '0;
    for (int i = 0; i < int'(NumUnits); i++) begin
      eligible[idx_t'(i)] = req_i[idx_t'(i)].we | can_read;
    end
  end

  // Scan downwards so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_sel   = rr_ptr_q;
    for (int k = int'(NumUnits) - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(NumUnits)) cand = cand - int'(NumUnits);
      if (req_valid_i[idx_t'(cand)] && eligible[idx_t'(cand)]) begin
        rr_found = 1'b1;
        rr_sel   = idx_t'(cand);
      end
    end
  end

  always_comb begin
    lock_live = (state_q == LOCK) && req_valid_i[lock_idx_q];
    if (hold_q) begin
      sel    = hold_idx_q;
      sel_ok = 1'b1;
    end else if (lock_live) begin
      sel    = lock_idx_q;
      sel_ok = 1'b1;
    end else begin
      sel    = rr_sel;
      sel_ok = rr_found;
    end
    sel_next = (sel == idx_t'(NumUnits - 1)) ? '0 : sel + idx_t'(1);

    way_o            = req_i[sel];
    way_valid_o      = sel_ok & req_valid_i[sel] & eligible[sel];
    req_ready_o      = '0;
    req_ready_o[sel] = way_ready_i & way_valid_o;
    handshake        = way_valid_o & way_ready_i;
  end

  // Out-of-range responses are sunk so a bad cache_unit cannot wedge the way.
  always_comb begin
    rsp_idx         = 32'(way_rsp_i.cache_unit);
    rsp_in_range    = (rsp_idx < NumUnits);
    rsp_o           = way_rsp_i;
    rsp_valid_o     = '0;
    way_rsp_ready_o = ~rsp_in_range;
    for (int i = 0; i < int'(NumUnits); i++) begin
      if (rsp_idx == 32'(i)) begin
        rsp_valid_o[idx_t'(i)] = way_rsp_valid_i;
        way_rsp_ready_o        = rsp_ready_i[idx_t'(i)];
      end
    end
    route_err_o = way_rsp_valid_i & ~rsp_in_range;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    burst_cnt_d = burst_cnt_q;
    burst_inc   = burst_cnt_q + BcW'(1);
    hold_d      = way_valid_o & ~way_ready_i;
    hold_idx_d  = hold_d ? sel : hold_idx_q;

    if (handshake) begin
      if (lock_live) begin
        burst_cnt_d = burst_inc;
        if (burst_inc == BcW'(MaxBurst)) begin
          state_d     = IDLE;
          rr_ptr_d    = sel_next;
          burst_cnt_d = '0;
        end
      end else begin
        rr_ptr_d = sel_next;
        if (MaxBurst > 1) begin
          state_d     = LOCK;
          lock_idx_d  = sel;
          burst_cnt_d = BcW'(1);
        end else begin
          state_d = IDLE;
        end
      end
    end else if ((state_q == LOCK) && !lock_live) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  always_comb begin
    rd_hs     = handshake & ~way_o.we;
    rsp_hs    = way_rsp_valid_i & way_rsp_ready_o;
    out_cnt_d = out_cnt_q;
    if (rd_hs && !rsp_hs) begin
      out_cnt_d = out_cnt_q + OcW'(1);
    end else if (!rd_hs && rsp_hs && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - OcW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      hold_idx_q  <= '0;
      burst_cnt_q <= '0;
      out_cnt_q   <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      hold_idx_q  <= hold_idx_d;
      burst_cnt_q <= burst_cnt_d;
      out_cnt_q   <= out_cnt_d;
      hold_q      <= hold_d;
    end
  end
endmodule

// File: tb/tb_axi_llc_way_arb.sv
// tb/tb_axi_llc_way_arb.sv - directed and randomized checks of axi_llc_way_arb
module tb_axi_llc_way_arb;
  import axi_llc_way_arb_pkg::*;

  localparam int NU = 4;
  localparam int MB = 4;
  localparam int MO = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  way_inp_t      req [NU];
  logic [NU-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  way_inp_t      way_req;
  logic          way_valid, way_ready;
  way_oup_t      way_rsp, rsp_bc;
  logic          way_rsp_valid, way_rsp_ready, route_err;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_rr, m_lock_idx, m_burst, m_out, m_hold_idx;
  bit m_lock, m_hold;

  // per-cycle observed and expected values
  int            obs_gnt, exp_gnt, exp_sel;
  logic          obs_way_valid, obs_rsp_ready, obs_err;
  logic [NU-1:0] obs_ready, obs_rsp_valid, exp_ready, exp_rsp_valid;
  way_inp_t      obs_way;
  bit            exp_vld, exp_rsp_ready, exp_err;

  always #5 clk = ~clk;

  axi_llc_way_arb #(.NumUnits(NU), .MaxBurst(MB), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .way_o(way_req), .way_valid_o(way_valid), .way_ready_i(way_ready),
    .way_rsp_i(way_rsp), .way_rsp_valid_i(way_rsp_valid), .way_rsp_ready_o(way_rsp_ready),
    .rsp_o(rsp_bc), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .route_err_o(route_err)
  );

  function automatic way_inp_t mk_req(int u, bit we);
    way_inp_t r;
    r.cache_unit = 4'(u);
    r.we         = we;
    r.line_addr  = 10'($urandom);
    r.blk_offset = 2'($urandom);
    r.data       = $urandom;
    r.strb       = 4'($urandom);
    return r;
  endfunction

  task automatic zero_inputs();
    for (int i = 0; i < NU; i++) req[i] = '0;
    req_valid = '0; way_ready = 1'b0; way_rsp = '0; way_rsp_valid = 1'b0; rsp_ready = '0;
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lock_idx = 0; m_burst = 0; m_out = 0; m_hold = 0; m_hold_idx = 0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Samples the DUT, evaluates the arbitration rules on the current inputs, then advances one clock.
  task automatic step();
    bit canrd, found, hs, rhs, rd;
    int c, cu;
    #1;
    obs_way_valid = way_valid; obs_ready = req_ready; obs_way = way_req;
    obs_rsp_valid = rsp_valid; obs_rsp_ready = way_rsp_ready; obs_err = route_err;
    obs_gnt = -1;
    for (int i = 0; i < NU; i++) if (way_valid && way_ready && req_ready[IW'(i)]) obs_gnt = i;

    canrd = (m_out < MO);
    if (m_hold) exp_sel = m_hold_idx;
    else if (m_lock && req_valid[IW'(m_lock_idx)]) exp_sel = m_lock_idx;
    else begin
      found = 0; exp_sel = m_rr;
      for (int k = 0; k < NU; k++) begin
        c = (m_rr + k) % NU;
        if (!found && req_valid[IW'(c)] && (req[IW'(c)].we || canrd)) begin found = 1; exp_sel = c; end
      end
    end
    exp_vld   = req_valid[IW'(exp_sel)] && (req[IW'(exp_sel)].we || canrd);
    exp_ready = '0;
    if (exp_vld && way_ready) exp_ready[IW'(exp_sel)] = 1'b1;
    exp_gnt = (exp_vld && way_ready) ? exp_sel : -1;

    cu = int'(way_rsp.cache_unit);
    exp_rsp_valid = '0; exp_rsp_ready = 1'b1; exp_err = way_rsp_valid;
    for (int i = 0; i < NU; i++) begin
      if (cu == i) begin exp_rsp_valid[IW'(i)] = way_rsp_valid; exp_rsp_ready = rsp_ready[IW'(i)]; exp_err = 0; end
    end

    hs  = exp_vld && way_ready;
    rhs = way_rsp_valid && exp_rsp_ready;
    rd  = hs && !req[IW'(exp_sel)].we;
    if (hs) begin
      if (m_lock && req_valid[IW'(m_lock_idx)]) begin
        m_burst++;
        if (m_burst == MB) begin m_lock = 0; m_rr = (exp_sel + 1) % NU; end
      end else begin
        m_rr = (exp_sel + 1) % NU;
        if (MB > 1) begin m_lock = 1; m_lock_idx = exp_sel; m_burst = 1; end
      end
    end else if (m_lock && !req_valid[IW'(m_lock_idx)]) m_lock = 0;
    m_hold = exp_vld && !way_ready; m_hold_idx = exp_sel;
    if (rd && !rhs) m_out++;
    else if (!rd && rhs && m_out > 0) m_out--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; zero_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (way_valid !== 1'b0 || req_ready !== '0) begin failures++; $display("FAIL reset_req got valid=%b ready=%b want 0/0", way_valid, req_ready); end
    checks++; if (way_req !== '0) begin failures++; $display("FAIL reset_way_o got=%h want=0", way_req); end
    checks++; if (rsp_valid !== '0 || way_rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_rsp got valid=%b ready=%b want 0/0", rsp_valid, way_rsp_ready); end
    checks++; if (rsp_bc !== '0 || route_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_o got=%h err=%b want 0/0", rsp_bc, route_err); end
    @(negedge clk);
    rst_n = 1'b1; model_reset();
    step();
    checks++; if (obs_gnt !== -1 || obs_way_valid !== 1'b0) begin failures++; $display("FAIL reset_idle got gnt=%0d valid=%b want -1/0", obs_gnt, obs_way_valid); end
  endtask

  task automatic test_alternate();
    int exp_seq[4];
    int last;
    exp_seq = '{0, 2, 0, 2};
    last = -1;
    apply_reset();
    rsp_ready = '1; way_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      req[0] = mk_req(0, 1'b0); req[2] = mk_req(2, 1'b0);
      req_valid[0] = (last != 0); req_valid[2] = (last != 2);
      way_rsp_valid = (last >= 0);
      way_rsp.cache_unit = 4'((last >= 0) ? last : 0); way_rsp.data = $urandom;
      step();
      checks++; if (obs_gnt !== exp_seq[n]) begin failures++; $display("FAIL alt_grant n=%0d got=%0d want=%0d", n, obs_gnt, exp_seq[n]); end
      if (last >= 0) begin
        checks++; if (obs_rsp_valid !== (NU'(1) << last)) begin failures++; $display("FAIL alt_rsp_valid n=%0d got=%b want unit %0d", n, obs_rsp_valid, last); end
      end
      last = obs_gnt;
    end
  endtask

  task automatic test_burst();
    int exp_seq[9];
    int got[$];
    int n1, n3;
    exp_seq = '{1, 1, 1, 1, 3, 1, 1, 1, 1};
    n1 = 0; n3 = 0;
    apply_reset();
    way_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && (n1 < 8 || n3 < 1); cyc++) begin
      req[1] = mk_req(1, 1'b1); req[3] = mk_req(3, 1'b1);
      req_valid[1] = (n1 < 8); req_valid[3] = (n3 < 1);
      step();
      if (obs_gnt == 1) n1++;
      if (obs_gnt == 3) n3++;
      if (obs_gnt >= 0) got.push_back(obs_gnt);
    end
    checks++; if (got.size() != 9) begin failures++; $display("FAIL burst_count got=%0d want=9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= got.size()) begin failures++; $display("FAIL burst_seq i=%0d got=none want=%0d", i, exp_seq[i]); end
      else if (got[i] != exp_seq[i]) begin failures++; $display("FAIL burst_seq i=%0d got=%0d want=%0d", i, got[i], exp_seq[i]); end
    end
  endtask

  task automatic test_out_cap();
    apply_reset();
    way_ready = 1'b1;
    for (int u = 0; u < 3; u++) begin req[u] = mk_req(u, 1'b0); req_valid[u] = 1'b1; end
    step();
    checks++; if (obs_gnt !== 0) begin failures++; $display("FAIL cap_first got=%0d want=0", obs_gnt); end
    req_valid[0] = 1'b0;
    step();
    checks++; if (obs_gnt !== 1) begin failures++; $display("FAIL cap_second got=%0d want=1", obs_gnt); end
    req_valid[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++; if (obs_way_valid !== 1'b0) begin failures++; $display("FAIL cap_block n=%0d got=%b want=0", n, obs_way_valid); end
    end
    way_rsp_valid = 1'b1; way_rsp.cache_unit = 4'd0; rsp_ready[0] = 1'b1;
    step();
    checks++; if (obs_way_valid !== 1'b0 || obs_rsp_ready !== 1'b1) begin failures++; $display("FAIL cap_rsp got valid=%b rsp_ready=%b want 0/1", obs_way_valid, obs_rsp_ready); end
    way_rsp_valid = 1'b0;
    step();
    checks++; if (obs_gnt !== 2) begin failures++; $display("FAIL cap_release got=%0d want=2", obs_gnt); end
  endtask

  task automatic test_simul();
    apply_reset();
    way_ready = 1'b1; rsp_ready = '1;
    req[0] = mk_req(0, 1'b0); req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0; req[1] = mk_req(1, 1'b0); req_valid[1] = 1'b1;
    way_rsp_valid = 1'b1; way_rsp.cache_unit = 4'd0;
    step();
    checks++; if (obs_gnt !== 1 || obs_rsp_ready !== 1'b1) begin failures++; $display("FAIL simul_both got gnt=%0d rsp_ready=%b want 1/1", obs_gnt, obs_rsp_ready); end
    req_valid[1] = 1'b0; way_rsp_valid = 1'b0; req[2] = mk_req(2, 1'b0); req_valid[2] = 1'b1;
    step();
    checks++; if (obs_gnt !== 2) begin failures++; $display("FAIL simul_one_left got=%0d want=2", obs_gnt); end
    req_valid[2] = 1'b0; req[3] = mk_req(3, 1'b0); req_valid[3] = 1'b1;
    step();
    checks++; if (obs_way_valid !== 1'b0) begin failures++; $display("FAIL simul_capped got=%b want=0", obs_way_valid); end
  endtask

  task automatic test_hold();
    way_inp_t held;
    apply_reset();
    held = mk_req(1, 1'b1); req[1] = held; req_valid[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (n == 1) begin req[0] = mk_req(0, 1'b1); req_valid[0] = 1'b1; end
      step();
      checks++; if (obs_way_valid !== 1'b1 || obs_way !== held || obs_ready !== '0) begin
        failures++; $display("FAIL hold_stable n=%0d got valid=%b way=%h ready=%b want 1/%h/0", n, obs_way_valid, obs_way, obs_ready, held);
      end
    end
    way_ready = 1'b1;
    step();
    checks++; if (obs_gnt !== 1) begin failures++; $display("FAIL hold_release got=%0d want=1", obs_gnt); end
    req_valid[1] = 1'b0;
    step();
    checks++; if (obs_gnt !== 0) begin failures++; $display("FAIL hold_next got=%0d want=0", obs_gnt); end
  endtask

  task automatic test_route_err();
    apply_reset();
    way_rsp_valid = 1'b1; way_rsp.cache_unit = 4'd5; way_rsp.data = $urandom;
    step();
    checks++; if (obs_rsp_ready !== 1'b1 || obs_rsp_valid !== '0 || obs_err !== 1'b1) begin
      failures++; $display("FAIL route_err got ready=%b valid=%b err=%b want 1/0/1", obs_rsp_ready, obs_rsp_valid, obs_err);
    end
    way_rsp_valid = 1'b0;
    step();
    checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL route_err_pulse got=%b want=0", obs_err); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) begin
        #2 rst_n = 1'b0;
        zero_inputs();
        #1;
        checks++; if (way_valid !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || route_err !== 1'b0) begin
          failures++; $display("FAIL mid_reset got valid=%b ready=%b rsp=%b err=%b want all 0", way_valid, req_ready, rsp_valid, route_err);
        end
        @(negedge clk);
        rst_n = 1'b1; model_reset();
      end
      for (int u = 0; u < NU; u++) begin
        if (!(m_hold && u == m_hold_idx)) begin
          req_valid[IW'(u)] = ($urandom_range(0, 99) < 60);
          req[IW'(u)] = mk_req(u, 1'($urandom_range(0, 1)));
        end
      end
      way_ready = ($urandom_range(0, 99) < 70);
      way_rsp_valid = (m_out > 0) && ($urandom_range(0, 2) != 0);
      way_rsp.cache_unit = ($urandom_range(0, 9) == 0) ? 4'd5 : 4'($urandom_range(0, NU - 1));
      way_rsp.data = $urandom;
      rsp_ready = NU'($urandom);
      step();
      checks++; if (obs_way_valid !== exp_vld) begin failures++; $display("FAIL rnd_way_valid cyc=%0d got=%b want=%b", cyc, obs_way_valid, exp_vld); end
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b want=%b", cyc, obs_ready, exp_ready); end
      if (exp_vld) begin
        checks++; if (obs_way !== req[IW'(exp_sel)]) begin failures++; $display("FAIL rnd_way_o cyc=%0d got=%h want=%h", cyc, obs_way, req[IW'(exp_sel)]); end
      end
      checks++; if (obs_rsp_valid !== exp_rsp_valid) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, obs_rsp_valid, exp_rsp_valid); end
      checks++; if (obs_rsp_ready !== exp_rsp_ready || obs_err !== exp_err) begin
        failures++; $display("FAIL rnd_rsp_ready cyc=%0d got ready=%b err=%b want %b/%b", cyc, obs_rsp_ready, obs_err, exp_rsp_ready, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_burst();
    test_out_cap();
    test_simul();
    test_hold();
    test_route_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
